pipelined_barrel_shifter: RTL and testbench

Parametrised, pipelined successor to the team's 8-bit combinational shifter. It supports logical shifts, arithmetic right shift and rotate in both directions. One register stage is placed per shift level (log2 WIDTH stages), with a valid/ready handshake and full-pipeline backpressure. It sits between an upstream producer and a downstream consumer in ALU/datapath blocks where the combinational shifter would close timing poorly.

---
 rtl/shifter_pkg.sv | 12 +
 rtl/pipelined_barrel_shifter_if.sv | 31 +++
 rtl/shift_stage.sv | 68 ++++++
 rtl/pipelined_barrel_shifter.sv | 62 ++++++
 tb/tb_pipelined_barrel_shifter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and mode type.
package shifter_pkg;

  typedef logic [2:0] shift_mode_t;

  localparam shift_mode_t MODE_SLL = 3'b000;
  localparam shift_mode_t MODE_SRL = 3'b001;
  localparam shift_mode_t MODE_SRA = 3'b010;
  localparam shift_mode_t MODE_ROL = 3'b011;
  localparam shift_mode_t MODE_ROR = 3'b100;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result bus of the pipelined barrel shifter; the producer/consumer side is master.
interface pipelined_barrel_shifter_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both high.
  // in_ready depends combinationally on out_valid/out_ready; valid never waits on ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  shift_mode_t      in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

endinterface

// File: rtl/shift_stage.sv
// One shift level: conditionally shifts/rotates by STEP when the matching amount bit is set,
// then registers data, amount, mode, valid and a zero flag, holding everything when en_i is low.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  shift_mode_t      mode_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output shift_mode_t      mode_o,
  output logic             zero_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [SHW-1:0]   amt_q;
  shift_mode_t      mode_q;
  logic             zero_q;

  // The MSB never changes under SRA, so the current MSB is the original sign bit.
  always_comb begin
    data_d = data_i;
    if (|(amt_i & SHW'(STEP))) begin
      case (mode_i)
        MODE_SLL: data_d = data_i << STEP;
        MODE_SRL: data_d = data_i >> STEP;
        MODE_SRA: data_d = $signed(data_i) >>> STEP;
        MODE_ROL: data_d = (data_i << STEP) | (data_i >> (WIDTH - STEP));
        MODE_ROR: data_d = (data_i >> STEP) | (data_i << (WIDTH - STEP));
        default:  data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= MODE_SLL;
      zero_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      mode_q  <= mode_i;
      zero_q  <= (data_d == '0);
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shifter/rotator: one register stage per shift level, whole-pipeline stall on
// output backpressure.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  pipelined_barrel_shifter_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             stall;
  logic             en;
  logic [SHW:0]     vld_s;
  logic [WIDTH-1:0] dat_s  [SHW+1];
  logic [SHW-1:0]   amt_s  [SHW+1];
  shift_mode_t      mode_s [SHW+1];
  logic [SHW-1:0]   zero_s;

  // Bubbles are kept during a stall; every stage freezes together.
  assign stall        = vld_s[SHW] && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  assign vld_s[0]  = bus.in_valid;
  assign dat_s[0]  = bus.in_data;
  assign amt_s[0]  = bus.in_amt;
  assign mode_s[0] = bus.in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STEP  (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .valid_i (vld_s[k]),
      .data_i  (dat_s[k]),
      .amt_i   (amt_s[k]),
      .mode_i  (mode_s[k]),
      .valid_o (vld_s[k+1]),
      .data_o  (dat_s[k+1]),
      .amt_o   (amt_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .zero_o  (zero_s[k])
    );
  end

  assign bus.out_valid = vld_s[SHW];
  assign bus.out_data  = dat_s[SHW];
  assign bus.out_zero  = zero_s[SHW-1];

  // Last-stage amount/mode and early zero flags have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_s[SHW], mode_s[SHW], zero_s};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for the pipelined barrel shifter (WIDTH=8 and WIDTH=32 instances).
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(8))  bus8 ();
  pipelined_barrel_shifter_if #(.WIDTH(32)) bus32 ();

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0]  exp_q[$];
  logic [32:0] exp32_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] amt, input shift_mode_t m,
                       input logic [7:0] e);
    int g = 0;
    bus8.in_valid = 1'b1;
    bus8.in_data  = d;
    bus8.in_amt   = amt;
    bus8.in_mode  = m;
    @(negedge clk);
    while (!bus8.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("w8_accept_wait_ok", 32'(g < 50), 32'd1);
    exp_q.push_back({(e == 8'h00), e});
    step();
    bus8.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] amt, input shift_mode_t m,
                        input logic [31:0] e);
    int g = 0;
    bus32.in_valid = 1'b1;
    bus32.in_data  = d;
    bus32.in_amt   = amt;
    bus32.in_mode  = m;
    @(negedge clk);
    while (!bus32.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("w32_accept_wait_ok", 32'(g < 50), 32'd1);
    exp32_q.push_back({(e == 32'h0), e});
    step();
    bus32.in_valid = 1'b0;
  endtask

  // Counts falling edges after an accept until out_valid shows the result.
  task automatic wait_lat(input bit wide, input int want, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wide ? bus32.out_valid : bus8.out_valid) && n < 40);
    chk(name, 32'(n), 32'(want));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp32_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q8_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_q32_empty", 32'(exp32_q.size()), 32'd0);
    step();
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon8
    logic [8:0] e;
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w8_spurious_output got=%h want=none", bus8.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("w8_out_data", 32'(bus8.out_data), 32'(e[7:0]));
        chk("w8_out_zero", 32'(bus8.out_zero), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin : mon32
    logic [32:0] e;
    if (rst_n && bus32.out_valid && bus32.out_ready) begin
      if (exp32_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w32_spurious_output got=%h want=none", bus32.out_data);
      end else begin
        e = exp32_q.pop_front();
        chk("w32_out_data", bus32.out_data, e[31:0]);
        chk("w32_out_zero", 32'(bus32.out_zero), 32'(e[32]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.in_amt    = '0;
    bus8.in_mode   = MODE_SLL;
    bus8.out_ready = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.in_data   = '0;
    bus32.in_amt    = '0;
    bus32.in_mode   = MODE_SLL;
    bus32.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus8.out_data), 32'd0);
    chk("rst_out_zero", 32'(bus8.out_zero), 32'd0);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    chk("rst_w32_out_valid", 32'(bus32.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single operation and its latency.
    send8(8'hB4, 3'd3, MODE_SLL, 8'hA0);
    wait_lat(1'b0, 3, "w8_latency_sll");
    drain();

    // Back-to-back, one result per cycle in order.
    send8(8'hB4, 3'd1, MODE_SRL, 8'h5A);
    send8(8'hB4, 3'd4, MODE_SRA, 8'hFB);
    send8(8'hB4, 3'd2, MODE_ROL, 8'hD2);
    send8(8'hB4, 3'd3, MODE_ROR, 8'h96);
    send8(8'h80, 3'd1, MODE_SLL, 8'h00);
    send8(8'h3C, 3'd5, 3'b111, 8'h3C);
    send8(8'hF0, 3'd3, 3'b101, 8'hF0);
    send8(8'h96, 3'd0, MODE_ROR, 8'h96);
    send8(8'h70, 3'd2, MODE_SRA, 8'h1C);
    send8(8'hFF, 3'd7, MODE_SRL, 8'h01);
    send8(8'h01, 3'd7, MODE_ROL, 8'h80);
    send8(8'h81, 3'd0, MODE_SRA, 8'h81);
    drain();

    // Backpressure: pipeline fills, then holds for five stalled cycles.
    bus8.out_ready = 1'b0;
    fork
      begin
        send8(8'h01, 3'd7, MODE_SLL, 8'h80);
        send8(8'hF0, 3'd7, MODE_SRA, 8'hFF);
        send8(8'h81, 3'd1, MODE_ROL, 8'h03);
        send8(8'h0F, 3'd4, MODE_SRL, 8'h00);
      end
      begin
        int n = 0;
        while (!bus8.out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 6; i++) begin
          chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
          chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
          chk("bp_hold_data", 32'(bus8.out_data), 32'h80);
          chk("bp_hold_zero", 32'(bus8.out_zero), 32'd0);
          if (i < 5) @(negedge clk);
        end
        step();
        bus8.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two items in flight.
    send8(8'h11, 3'd1, MODE_SLL, 8'h22);
    send8(8'h22, 3'd1, MODE_SLL, 8'h44);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus8.out_data), 32'd0);
    chk("midrst_out_zero", 32'(bus8.out_zero), 32'd0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_output", 32'(bus8.out_valid), 32'd0);
    end
    step();
    send8(8'h3C, 3'd2, MODE_SLL, 8'hF0);
    wait_lat(1'b0, 3, "w8_latency_after_reset");
    drain();

    // 32-bit instance.
    send32(32'h8000_0001, 5'd31, MODE_ROR, 32'h0000_0003);
    wait_lat(1'b1, 5, "w32_latency_ror");
    drain();
    send32(32'h8000_0001, 5'd31, MODE_SRA, 32'hFFFF_FFFF);
    send32(32'h1234_5678, 5'd16, MODE_ROL, 32'h5678_1234);
    send32(32'h8000_0000, 5'd31, MODE_SRL, 32'h0000_0001);
    send32(32'h0000_0002, 5'd31, MODE_SLL, 32'h0000_0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL global_timeout got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
